// File: rtl/frame_buffer_axi_sink.sv
// AXI4-Lite write-only sink for one frame of GRB pixels with a registered display read port.
// Writes are accepted only with AW and W presented together; completion is flagged per full frame.
module frame_buffer_axi_sink #(
   parameter int unsigned BASE_ADDR  = 0,
   parameter int unsigned NUM_PIXELS = 4096,
   parameter int unsigned PIX_W      = 24,
   parameter int unsigned IDX_W      = $clog2(NUM_PIXELS)
) (
   input  logic               CLK100MHZ,
   input  logic               RST_SYS,
   input  logic [31:0]        S_AXI_AWADDR,
   input  logic               S_AXI_AWVALID,
   output logic               S_AXI_AWREADY,
   input  logic [31:0]        S_AXI_WDATA,
   input  logic [3:0]         S_AXI_WSTRB,
   input  logic               S_AXI_WVALID,
   output logic               S_AXI_WREADY,
   output logic [1:0]         S_AXI_BRESP,
   output logic               S_AXI_BVALID,
   input  logic               S_AXI_BREADY,
   input  logic               RD_EN,
   input  logic [IDX_W-1:0]   RD_ADDR,
   output logic [PIX_W-1:0]   RD_DATA,
   output logic               FRAME_DONE,
   output logic               FRAME_VALID,
   input  logic               FRAME_CLR,
   output logic [IDX_W:0]     PIX_COUNT
);

   localparam int unsigned    LANES    = PIX_W / 8;
   localparam logic [31:0]    BASE_32  = 32'(BASE_ADDR);
   localparam logic [31:0]    NUM_32   = 32'(NUM_PIXELS);
   localparam logic [IDX_W:0] PIX_FULL = (IDX_W+1)'(NUM_PIXELS);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PIXELS - 1);
   localparam logic [1:0]     RESP_OKAY   = 2'b00;
   localparam logic [1:0]     RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {S_IDLE, S_WRITE, S_RESP} state_t;

   state_t state, state_nxt;
   logic   accept;

   logic [31:0]      aw_addr_p0;
   logic [PIX_W-1:0] w_data_p0;
   logic [LANES-1:0] w_strb_p0;

   logic [31:0]      off_p0;
   logic [31:0]      quot_p0;
   logic [31:0]      rem_p0;
   logic [31:0]      idx_full_p0;
   logic [IDX_W-1:0] idx_p0;
   logic             legal_p0;
   logic             commit_p0;
   logic             rd_in_range;

   logic [PIX_W-1:0] mem [NUM_PIXELS];

   logic unused_bits;
   assign unused_bits = ^{S_AXI_WDATA[31:PIX_W], S_AXI_WSTRB[3:LANES]};

   // Control FSM
   always_ff @(posedge CLK100MHZ) begin
      if (RST_SYS) state <= S_IDLE;
      else         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      case (state)
         S_IDLE: begin
            if (S_AXI_AWVALID && S_AXI_WVALID) begin
               accept    = 1'b1;
               state_nxt = S_WRITE;
            end
         end
         S_WRITE: state_nxt = S_RESP;
         S_RESP:  if (S_AXI_BREADY) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Both readies rise together so a master never sees a lone channel accepted
   assign S_AXI_AWREADY = accept && !RST_SYS;
   assign S_AXI_WREADY  = accept && !RST_SYS;
   assign S_AXI_BVALID  = (state == S_RESP);

   // Stage p0: capture the accepted address/data
   always_ff @(posedge CLK100MHZ) begin
      if (accept) begin
         aw_addr_p0 <= S_AXI_AWADDR;
         w_data_p0  <= S_AXI_WDATA[PIX_W-1:0];
         w_strb_p0  <= S_AXI_WSTRB[LANES-1:0];
      end
   end

   // Byte offset to pixel index; slot 0 sits one stride above BASE_ADDR
   assign off_p0      = aw_addr_p0 - BASE_32;
   assign quot_p0     = off_p0 / 32'd3;
   assign rem_p0      = off_p0 - quot_p0 * 32'd3;
   assign idx_full_p0 = quot_p0 - 32'd1;
   assign idx_p0      = idx_full_p0[IDX_W-1:0];
   assign legal_p0    = (off_p0 >= 32'd3) && (rem_p0 == 32'd0) && (idx_full_p0 < NUM_32);
   assign commit_p0   = (state == S_WRITE) && legal_p0 && !RST_SYS;

   always_ff @(posedge CLK100MHZ) begin
      if (RST_SYS)               S_AXI_BRESP <= RESP_OKAY;
      else if (state == S_WRITE) S_AXI_BRESP <= legal_p0 ? RESP_OKAY : RESP_SLVERR;
   end

   always_ff @(posedge CLK100MHZ) begin
      if (commit_p0) begin
         for (int i = 0; i < int'(LANES); i++) begin
            if (w_strb_p0[i]) mem[idx_p0][i*8 +: 8] <= w_data_p0[i*8 +: 8];
         end
      end
   end

   generate
      if (NUM_PIXELS == (1 << IDX_W)) begin : g_full_range
         assign rd_in_range = 1'b1;
      end else begin : g_part_range
         assign rd_in_range = ({1'b0, RD_ADDR} < PIX_FULL);
      end
   endgenerate

   // Read-first: a same-cycle write to RD_ADDR is not forwarded
   always_ff @(posedge CLK100MHZ) begin
      if (RST_SYS)    RD_DATA <= '0;
      else if (RD_EN) RD_DATA <= rd_in_range ? mem[RD_ADDR] : '0;
   end

   // Frame bookkeeping; a coincident clear beats the commit, but the done pulse survives
   always_ff @(posedge CLK100MHZ) begin
      if (RST_SYS) begin
         PIX_COUNT   <= '0;
         FRAME_VALID <= 1'b0;
         FRAME_DONE  <= 1'b0;
      end else begin
         FRAME_DONE <= commit_p0 && (idx_p0 == LAST_IDX);
         if (FRAME_CLR) begin
            PIX_COUNT   <= '0;
            FRAME_VALID <= 1'b0;
         end else if (commit_p0) begin
            if (PIX_COUNT != PIX_FULL) PIX_COUNT <= PIX_COUNT + 1'b1;
            if (idx_p0 == LAST_IDX)    FRAME_VALID <= 1'b1;
         end
      end
   end

endmodule
